// File: rtl/pipe_reg_skid_pkg.sv
// Shared types for the skid-buffered pipeline stage register.
// State encodings and occupancy decode used by the top and the bench.
package pipe_reg_skid_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_BUSY  = 2'b01,
        ST_FULL  = 2'b10
    } state_e;

    localparam int STATE_W = 2;

    function automatic logic [1:0] occ_of(input state_e s);
        logic [1:0] occ;
        occ = 2'd0;
        unique case (s)
            ST_BUSY: occ = 2'd1;
            ST_FULL: occ = 2'd2;
            default: occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/pipe_reg_skid_dffe_bank.sv
// Enable register bank with synchronous reset.
// The active clock edge is chosen at elaboration time.
module dffe_bank #(
    parameter int               WIDTH     = 1,
    parameter bit               NEG_EDGE  = 1'b0,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    generate
        if (NEG_EDGE) begin : g_neg
            always_ff @(negedge clk_i) begin
                if (rst_i) begin
                    q_o <= RESET_VAL;
                end else if (en_i) begin
                    q_o <= d_i;
                end
            end
        end else begin : g_pos
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    q_o <= RESET_VAL;
                end else if (en_i) begin
                    q_o <= d_i;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/pipe_reg_skid.sv
// Pipeline stage register with valid/ready handshake and one skid entry.
// Handshake outputs come straight from the state flops.
module pipe_reg_skid
    import pipe_reg_skid_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter bit NEG_EDGE       = 1'b0,
    parameter bit CLEAR_ON_FLUSH = 1'b0
) (
    input  logic             clock,
    input  logic             ctrl_reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    state_e             state_q;
    state_e             state_d;
    logic [STATE_W-1:0] state_raw_q;
    logic [WIDTH-1:0]   main_q;
    logic [WIDTH-1:0]   main_d;
    logic [WIDTH-1:0]   skid_q;
    logic [WIDTH-1:0]   skid_d;
    logic               main_en;
    logic               skid_en;
    logic               main_from_skid;
    logic               push;
    logic               pop;
    logic               clear;

    assign state_q   = state_e'(state_raw_q);
    assign out_valid = (state_q != ST_EMPTY);
    assign in_ready  = (state_q != ST_FULL);
    assign occupancy = occ_of(state_q);
    assign out_data  = main_q;

    assign push  = in_valid & in_ready;
    assign pop   = out_valid & out_ready;
    assign clear = flush & CLEAR_ON_FLUSH;

    always_comb begin
        state_d        = state_q;
        main_en        = 1'b0;
        skid_en        = 1'b0;
        main_from_skid = 1'b0;
        unique case (state_q)
            ST_EMPTY: begin
                if (push) begin
                    state_d = ST_BUSY;
                    main_en = 1'b1;
                end
            end
            ST_BUSY: begin
                if (push && pop) begin
                    main_en = 1'b1;
                end else if (push) begin
                    state_d = ST_FULL;
                    skid_en = 1'b1;
                end else if (pop) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (pop) begin
                    state_d        = ST_BUSY;
                    main_en        = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        // Flush overrides any push/pop; data regs only move when clearing.
        if (flush) begin
            state_d = ST_EMPTY;
            main_en = CLEAR_ON_FLUSH;
            skid_en = CLEAR_ON_FLUSH;
        end
    end

    assign main_d = clear ? '0 : (main_from_skid ? skid_q : in_data);
    assign skid_d = clear ? '0 : in_data;

    dffe_bank #(
        .WIDTH    (STATE_W),
        .NEG_EDGE (NEG_EDGE),
        .RESET_VAL(ST_EMPTY)
    ) u_state (
        .clk_i(clock),
        .rst_i(ctrl_reset),
        .en_i (1'b1),
        .d_i  (state_d),
        .q_o  (state_raw_q)
    );

    dffe_bank #(
        .WIDTH    (WIDTH),
        .NEG_EDGE (NEG_EDGE),
        .RESET_VAL('0)
    ) u_main (
        .clk_i(clock),
        .rst_i(ctrl_reset),
        .en_i (main_en),
        .d_i  (main_d),
        .q_o  (main_q)
    );

    dffe_bank #(
        .WIDTH    (WIDTH),
        .NEG_EDGE (NEG_EDGE),
        .RESET_VAL('0)
    ) u_skid (
        .clk_i(clock),
        .rst_i(ctrl_reset),
        .en_i (skid_en),
        .d_i  (skid_d),
        .q_o  (skid_q)
    );

endmodule

// File: tb/tb_pipe_reg_skid.sv
// Bench for pipe_reg_skid: rising-edge and falling-edge builds side by side.
// The falling-edge build is clocked by the inverted clock so both update together.
module tb_pipe_reg_skid;

    logic        clk;
    logic        clk_n;
    logic        rst;
    logic        fl;
    logic        iv;
    logic [31:0] din;
    logic        ordy;

    logic        ir0, ov0, ir1, ov1;
    logic [31:0] dout0, dout1;
    logic [1:0]  occ0, occ1;

    int nvec;
    int nerr;
    logic [31:0] q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    assign clk_n = ~clk;

    pipe_reg_skid #(.WIDTH(32), .NEG_EDGE(1'b0), .CLEAR_ON_FLUSH(1'b0)) dut0 (
        .clock(clk), .ctrl_reset(rst), .flush(fl),
        .in_valid(iv), .in_ready(ir0), .in_data(din),
        .out_valid(ov0), .out_ready(ordy), .out_data(dout0),
        .occupancy(occ0)
    );

    pipe_reg_skid #(.WIDTH(32), .NEG_EDGE(1'b1), .CLEAR_ON_FLUSH(1'b0)) dut1 (
        .clock(clk_n), .ctrl_reset(rst), .flush(fl),
        .in_valid(iv), .in_ready(ir1), .in_data(din),
        .out_valid(ov1), .out_ready(ordy), .out_data(dout1),
        .occupancy(occ1)
    );

    task automatic chk(input string nm, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] e);
        nvec++;
        if (a !== e || b !== e) begin
            nerr++;
            $display("FAIL %s: pos-edge=%h neg-edge=%h expected=%h", nm, a, b, e);
        end
    endtask

    task automatic chk_state(input string nm, input logic e_ov, input logic e_ir,
                             input logic [1:0] e_occ, input logic [31:0] e_d,
                             input bit chk_data);
        chk({nm, ".out_valid"}, 32'(ov0), 32'(ov1), 32'(e_ov));
        chk({nm, ".in_ready"}, 32'(ir0), 32'(ir1), 32'(e_ir));
        chk({nm, ".occupancy"}, 32'(occ0), 32'(occ1), 32'(e_occ));
        if (chk_data) chk({nm, ".out_data"}, dout0, dout1, e_d);
    endtask

    // Drive one cycle, update the scoreboard, then advance past the edge.
    task automatic cycle(input logic r, input logic f, input logic v,
                         input logic [31:0] d, input logic o);
        logic pu, po;
        rst = r; fl = f; iv = v; din = d; ordy = o;
        #1;
        pu = v & ir0;
        po = ov0 & o;
        if (r) begin
            q.delete();
        end else begin
            if (po) begin
                if (q.size() == 0) begin
                    nvec++; nerr++;
                    $display("FAIL pop_unexpected: got=%h expected=none", dout0);
                end else begin
                    chk("pop_data", dout0, dout1, q.pop_front());
                end
            end
            if (f) q.delete();
            else if (pu) q.push_back(d);
        end
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        r, f, v;
        logic [31:0] d;
        logic        o;
        logic        e_ov, e_ir;
        logic [1:0]  e_occ;
        logic [31:0] e_d;
    } vec_t;

    vec_t tbl[16];

    initial begin
        nvec = 0; nerr = 0;
        rst = 1'b1; fl = 1'b0; iv = 1'b0; din = '0; ordy = 1'b0;
        //             r  f  v  d            o  ov ir occ  data
        tbl[0]  = '{1, 0, 1, 32'h55,     0, 0, 1, 0, 32'h0};
        tbl[1]  = '{1, 0, 1, 32'h66,     0, 0, 1, 0, 32'h0};
        tbl[2]  = '{0, 0, 1, 32'hA,      0, 1, 1, 1, 32'hA};
        tbl[3]  = '{0, 0, 1, 32'hB,      0, 1, 0, 2, 32'hA};
        tbl[4]  = '{0, 0, 1, 32'hD,      0, 1, 0, 2, 32'hA};
        tbl[5]  = '{0, 0, 0, 32'h0,      1, 1, 1, 1, 32'hB};
        tbl[6]  = '{0, 0, 0, 32'h0,      1, 0, 1, 0, 32'hB};
        tbl[7]  = '{0, 0, 1, 32'hE,      0, 1, 1, 1, 32'hE};
        tbl[8]  = '{0, 0, 1, 32'hF,      0, 1, 0, 2, 32'hE};
        tbl[9]  = '{0, 1, 1, 32'hC,      0, 0, 1, 0, 32'hE};
        tbl[10] = '{0, 0, 1, 32'h7,      0, 1, 1, 1, 32'h7};
        tbl[11] = '{0, 1, 0, 32'h0,      1, 0, 1, 0, 32'h7};
        tbl[12] = '{0, 0, 1, 32'h1,      0, 1, 1, 1, 32'h1};
        tbl[13] = '{0, 0, 1, 32'h2,      0, 1, 0, 2, 32'h1};
        tbl[14] = '{1, 1, 1, 32'h3,      1, 0, 1, 0, 32'h0};
        tbl[15] = '{0, 0, 0, 32'h0,      1, 0, 1, 0, 32'h0};

        @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) begin
            cycle(tbl[i].r, tbl[i].f, tbl[i].v, tbl[i].d, tbl[i].o);
            chk_state($sformatf("vec%0d", i), tbl[i].e_ov, tbl[i].e_ir,
                      tbl[i].e_occ, tbl[i].e_d, 1'b1);
        end

        for (int k = 1; k <= 16; k++) begin
            cycle(1'b0, 1'b0, 1'b1, 32'(k), 1'b1);
            chk_state($sformatf("stream%0d", k), 1'b1, 1'b1, 2'd1, 32'(k), 1'b1);
        end
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk_state("stream_drain", 1'b0, 1'b1, 2'd0, 32'h10, 1'b1);

        for (int c = 0; c < 10000; c++) begin
            cycle(1'b0, ($urandom_range(0, 63) == 0), 1'($urandom),
                  $urandom, 1'($urandom));
            chk_state("rand", q.size() != 0, q.size() != 2,
                      2'(q.size()), 32'h0, 1'b0);
        end

        for (int c = 0; c < 3; c++) cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk_state("final_drain", 1'b0, 1'b1, 2'd0, 32'h0, 1'b0);
        chk("scoreboard_empty", 32'(q.size()), 32'(q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
